// File: rtl/product_accumulator_pkg.sv
// Shared types, default widths and the saturating-add helper for the
// product accumulator.
package product_accumulator_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 12;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Returns {overflow, saturated_sum} for the default widths.
    function automatic logic [ACC_W_DEF:0] sat_add(
        input logic [ACC_W_DEF-1:0]  acc,
        input logic [PROD_W_DEF-1:0] prod
    );
        logic [ACC_W_DEF:0] s;
        s = {1'b0, acc} + {{(ACC_W_DEF + 1 - PROD_W_DEF){1'b0}}, prod};
        if (s[ACC_W_DEF]) begin
            return {1'b1, {ACC_W_DEF{1'b1}}};
        end
        return s;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational unsigned ACC_W + PROD_W adder that clamps to all ones
// on carry-out and flags the overflow.
module sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    generate
        if (ACC_W == ACC_W_DEF && PROD_W == PROD_W_DEF) begin : g_pkg
            logic [ACC_W_DEF:0] r;
            // Default widths reuse the package helper directly.
            assign r   = sat_add(acc, prod);
            assign ovf = r[ACC_W_DEF];
            assign sum = r[ACC_W_DEF-1:0];
        end else begin : g_gen
            logic [ACC_W:0] s;
            // Extra bit of headroom catches the carry-out.
            assign s   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
            assign ovf = s[ACC_W];
            assign sum = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums 1..2^LEN_W unsigned products into a
// saturating accumulator and hands the result off over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACC   | accepting terms; acc_o shows the running sum
// HOLD  | result complete; acc_o/cnt_o/sat_o frozen until taken
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              clear_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic [LEN_W:0]    cnt_o,
    output logic              sat_o,
    output logic              acc_valid_o,
    input  logic              acc_ready_i
);

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W:0]     cnt;
    logic               sat;
    logic [LEN_W-1:0]   len_q;

    logic               accept;
    logic               take;
    logic [LEN_W-1:0]   eff_len;
    logic               last_term;
    logic [ACC_W-1:0]   sum;
    logic               ovf;

    sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_adder (
        .acc  (acc),
        .prod (prod_i),
        .sum  (sum),
        .ovf  (ovf)
    );

    // Handshake decode depends only on state, ena and clear_i.
    assign prod_ready_o = ena & (state == ACC) & ~clear_i;
    assign acc_valid_o  = (state == HOLD);

    assign accept = prod_valid_i & prod_ready_o;
    assign take   = acc_valid_o & acc_ready_i & ena;

    // The first term of a result compares against the live len_i, later
    // terms against the value captured with that first term.
    assign eff_len   = (cnt == '0) ? len_i : len_q;
    assign last_term = (cnt == {1'b0, eff_len});

    // Accumulator FSM: clear beats accept and take; ena low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
            len_q <= '0;
        end else if (ena) begin
            if (clear_i) begin
                state <= ACC;
                acc   <= '0;
                cnt   <= '0;
                sat   <= 1'b0;
            end else if (accept) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
                sat <= sat | ovf;
                if (cnt == '0) begin
                    len_q <= len_i;
                end
                if (last_term) begin
                    state <= HOLD;
                end
            end else if (take) begin
                state <= ACC;
                acc   <= '0;
                cnt   <= '0;
                sat   <= 1'b0;
            end
        end
    end

    assign acc_o = acc;
    assign cnt_o = cnt;
    assign sat_o = sat;

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator placed directly downstream of the 4×4 array multiplier. It consumes the 8-bit product one term per accepted handshake and sums a programmable number of terms (1..16) into a saturating accumulator. It presents the finished dot-product with a valid/ready handshake, which turns the combinational multiplier into a multiply-accumulate datapath.

## Interface
Parameters:
- PROD_W, 8, product width; matches the multiplier output `p`.
- ACC_W, 12, accumulator width; must be ≥ PROD_W + 1.
- LEN_W, 4, term-count field width; each result sums up to 2^LEN_W terms.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  global enable; when low, all state freezes.
- prod_i  in  PROD_W  product from the multiplier.
- prod_valid_i  in  1  prod_i holds a term.
- prod_ready_o  out  1  block accepts a term this cycle.
- len_i  in  LEN_W  number of terms minus 1; sampled on the first term of each result.
- clear_i  in  1  synchronous abort: discards the partial sum.
- acc_o  out  ACC_W  accumulator register; shows the running sum, or the final sum in HOLD.
- cnt_o  out  LEN_W+1  number of terms accepted into the current result.
- sat_o  out  1  sticky saturation flag for the current result.
- acc_valid_o  out  1  acc_o holds a finished result.
- acc_ready_i  in  1  consumer takes the result.

## Operation
- States: ACC and HOLD. Reset state is ACC.
- Term handshake:
  - prod_ready_o = ena & (state==ACC) & ~clear_i.
  - A term is accepted when prod_valid_i & prod_ready_o.
- Result handshake:
  - acc_valid_o = (state==HOLD).
  - A result is taken when acc_valid_o & acc_ready_i & ena.
- ACC state, on accept:
  - acc ← sat(acc + zero-extended prod_i).
  - cnt ← cnt+1.
  - If cnt==0, len_q ← len_i. That same cycle's comparison uses len_i.
  - If cnt equals the effective length, go to HOLD.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - If the carry-out is 1, acc ← all ones and sat ← 1.
  - sat stays set until the result is taken, clear_i, or reset.
- HOLD state:
  - acc_o, cnt_o and sat_o are frozen; no terms are accepted.
  - When the result is taken: acc, cnt and sat ← 0, state ← ACC.
- clear_i (with ena high):
  - Next cycle: acc, cnt and sat ← 0, state ← ACC, from either state.
  - clear_i has priority over accept and take. A product offered in the same cycle is not accepted (ready is low).
- ena low:
  - No accept, no take, and clear_i is ignored.
  - All registers hold.
  - Reset still acts.
- Reset (rst_n low at an edge):
  - acc_o=0, cnt_o=0, sat_o=0, state=ACC.
  - acc_valid_o=0; prod_ready_o follows its equation.
  - A reset mid-result discards the partial sum.
- prod_i is treated as unsigned; no sign extension.

## Timing
- Accept at edge N: acc_o and cnt_o show the updated value after edge N (1-cycle latency).
- Last term accepted at edge N: acc_valid_o is high from edge N through the take edge. There is no bubble beyond that.
- Take at edge M: prod_ready_o is high after M, so the first term of the next result can be accepted at M+1.
- Throughput:
  - One term per cycle while in ACC.
  - A result of L terms occupies L accept cycles plus at least 1 HOLD cycle.
- All outputs come straight from registers, except prod_ready_o and acc_valid_o. Those are decoded from state, ena and clear_i, with no input-to-output path from prod_valid_i or acc_ready_i.

## Structure
- Package `product_accumulator_pkg` holds:
  - the state enum (ACC, HOLD);
  - default constants PROD_W, ACC_W, LEN_W;
  - a function returning the saturated sum.
- One sub-module, `sat_adder`: combinational ACC_W-bit + PROD_W-bit unsigned adder with saturate, outputting sum and overflow.
- The top contains the FSM, the counter, len_q, and the handshake logic.

## Test plan
- Nominal 4 terms:
  - Stimulus: len_i=3, products 225 ×4 back-to-back, acc_ready_i=1.
  - Response: acc_o=900 (0x384) with acc_valid_o high one cycle after the 4th accept; sat_o=0; cnt_o=4.
- Single term with consumer stall:
  - Stimulus: len_i=0, product 42, acc_ready_i held low 5 cycles.
  - Response: acc_o=42 stable and prod_ready_o=0 for all 5 cycles; after the take, acc_o=0 and prod_ready_o=1.
- Saturation (ACC_W=10):
  - Stimulus: len_i=4, products 225 ×5.
  - Response: after the 5th term acc_o=1023, sat_o=1.
  - Next result, 2 terms of 1 with len_i=1: acc_o=2, sat_o=0.
- Clear mid-result:
  - Stimulus: len_i=7, 3 terms of 10, then clear_i together with prod_valid_i.
  - Response: the clear cycle is not accepted; next cycle acc_o=0, cnt_o=0; a following 8-term sequence of 1 gives acc_o=8.
- ena gating:
  - Stimulus: ena low for 3 cycles while prod_valid_i=1 and clear_i=1.
  - Response: no accept, no clear; acc_o and cnt_o unchanged.
- Reset mid-result:
  - Stimulus: rst_n low 1 cycle after 2 of 4 terms.
  - Response: acc_o=0, cnt_o=0, acc_valid_o=0; a fresh len_i is sampled on the next first term.
